// File: rtl/rx_pkg.sv
// Shared types and constants for the USB full-speed receive bit front end.
package rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StEop
  } rx_fe_state_t;

  localparam logic [7:0]  SYNC_BYTE        = 8'h80;
  localparam int unsigned MAX_ONES_RUN     = 6;
  localparam int unsigned DEF_CLKS_PER_BIT = 8;
  localparam int unsigned DEF_SAMPLE_PT    = 3;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: free-runs while enabled, resyncs to zero on a line edge,
// and pulses sample once per bit at SAMPLE_PT.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SAMPLE_PT    = DEF_SAMPLE_PT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic resync,
  output logic sample
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (!en || resync) begin
      count_d = '0;
    end else if (count_q == TW'(CLKS_PER_BIT - 1)) begin
      count_d = '0;
    end else begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sample = en && !resync && (count_q == TW'(SAMPLE_PT));

endmodule

// File: rtl/rx_bit_frontend.sv
// USB FS receive bit front end: sync, bit timing, NRZI decode, unstuffing, byte
// assembly and SE0 EOP. Define RX_STUFF_ERR_EN to flag and abort on stuff violations.
module rx_bit_frontend
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SAMPLE_PT    = DEF_SAMPLE_PT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic       clear_byte_received,
  output logic       d_edge,
  output logic       eop,
  output logic       byte_received,
  output logic [7:0] rcv_data,
  output logic [3:0] count_bytes,
  output logic       stuff_error
);

`ifdef RX_STUFF_ERR_EN
  localparam bit StuffErrEn = 1'b1;
`else
  localparam bit StuffErrEn = 1'b0;
`endif

  logic         dp_meta_q, sdp_q, sdp_dly_q, dm_meta_q, sdm_q;
  logic         d_edge_q;
  rx_fe_state_t state_d, state_q;
  logic         eop_d, eop_q;
  logic         prev_d, prev_q;
  logic [2:0]   ones_d, ones_q;
  logic [2:0]   bit_cnt_d, bit_cnt_q;
  logic [7:0]   shift_d, shift_q;
  logic [7:0]   rcv_data_d, rcv_data_q;
  logic         byte_rcvd_d, byte_rcvd_q;
  logic [3:0]   count_d, count_q;
  logic         stuff_err_d, stuff_err_q;
  logic         sample, se0, bit_val, pkt_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_meta_q <= 1'b1;
      sdp_q     <= 1'b1;
      sdp_dly_q <= 1'b1;
      dm_meta_q <= 1'b0;
      sdm_q     <= 1'b0;
      d_edge_q  <= 1'b0;
    end else begin
      dp_meta_q <= dplus_in;
      sdp_q     <= dp_meta_q;
      sdp_dly_q <= sdp_q;
      dm_meta_q <= dminus_in;
      sdm_q     <= dm_meta_q;
      d_edge_q  <= sdp_q ^ sdp_dly_q;
    end
  end

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PT    (SAMPLE_PT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != StIdle),
    .resync (d_edge_q && (state_q == StActive)),
    .sample (sample)
  );

  assign se0     = !sdp_q && !sdm_q;
  assign bit_val = (sdp_q == prev_q);
  // Only a move away from J starts a packet; the J that closes an EOP must not.
  assign pkt_start = d_edge_q && !sdp_dly_q;

  always_comb begin
    state_d     = state_q;
    eop_d       = eop_q;
    prev_d      = prev_q;
    ones_d      = ones_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rcv_data_d  = rcv_data_q;
    byte_rcvd_d = clear_byte_received ? 1'b0 : byte_rcvd_q;
    count_d     = count_q;
    stuff_err_d = stuff_err_q;

    unique case (state_q)
      StIdle: begin
        if (pkt_start) begin
          state_d     = StActive;
          prev_d      = 1'b1;
          ones_d      = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          byte_rcvd_d = 1'b0;
          count_d     = '0;
          stuff_err_d = 1'b0;
        end
      end
      StActive: begin
        if (sample) begin
          if (se0) begin
            state_d   = StEop;
            eop_d     = 1'b1;
            bit_cnt_d = '0;
          end else begin
            prev_d = sdp_q;
            if (ones_q == 3'(MAX_ONES_RUN)) begin
              ones_d = '0;
              if (StuffErrEn && bit_val) begin
                stuff_err_d = 1'b1;
                state_d     = StEop;
                bit_cnt_d   = '0;
              end
            end else begin
              ones_d  = bit_val ? ones_q + 3'd1 : 3'd0;
              shift_d = {bit_val, shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                rcv_data_d  = {bit_val, shift_q[7:1]};
                byte_rcvd_d = 1'b1;
                bit_cnt_d   = '0;
                if (count_q != 4'hF) count_d = count_q + 4'd1;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end
          end
        end
      end
      StEop: begin
        // eop low here means the EOP state was entered on a stuff violation.
        if (!eop_q) begin
          if ((sample && !se0) || d_edge_q) state_d = StIdle;
        end else if (!se0) begin
          state_d = StIdle;
          eop_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      eop_q       <= 1'b0;
      prev_q      <= 1'b1;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rcv_data_q  <= '0;
      byte_rcvd_q <= 1'b0;
      count_q     <= '0;
      stuff_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      eop_q       <= eop_d;
      prev_q      <= prev_d;
      ones_q      <= ones_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rcv_data_q  <= rcv_data_d;
      byte_rcvd_q <= byte_rcvd_d;
      count_q     <= count_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign d_edge        = d_edge_q;
  assign eop           = eop_q;
  assign byte_received = byte_rcvd_q;
  assign rcv_data      = rcv_data_q;
  assign count_bytes   = count_q;
  assign stuff_error   = stuff_err_q;

endmodule

// File: tb/tb_rx_bit_frontend.sv
// Directed bench for rx_bit_frontend at 8 clk/bit; honours RX_STUFF_ERR_EN.
module tb_rx_bit_frontend;
  import rx_pkg::*;

  logic       clk = 1'b0;
  logic       rst, dplus_in, dminus_in, clear_byte_received;
  logic       d_edge, eop, byte_received, stuff_error;
  logic [7:0] rcv_data;
  logic [3:0] count_bytes;
  int         checks = 0;
  int         errors = 0;
  int         edge_cnt = 0;
  int         edge_base;

  rx_bit_frontend dut (
    .clk                 (clk),
    .rst                 (rst),
    .dplus_in            (dplus_in),
    .dminus_in           (dminus_in),
    .clear_byte_received (clear_byte_received),
    .d_edge              (d_edge),
    .eop                 (eop),
    .byte_received       (byte_received),
    .rcv_data            (rcv_data),
    .count_bytes         (count_bytes),
    .stuff_error         (stuff_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (d_edge === 1'b1) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every drive starts and ends 1 time unit after a rising edge.
  task automatic hold(input logic dp, input logic dm, input int n);
    dplus_in  = dp;
    dminus_in = dm;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_j(input int n);   hold(1'b1, 1'b0, n); endtask
  task automatic drive_k(input int n);   hold(1'b0, 1'b1, n); endtask
  task automatic drive_se0(input int n); hold(1'b0, 1'b0, n); endtask

  // KJKJKJKK
  task automatic send_sync();
    drive_k(8); drive_j(8); drive_k(8); drive_j(8);
    drive_k(8); drive_j(8); drive_k(16);
  endtask

  initial begin
    rst = 1'b1; dplus_in = 1'b1; dminus_in = 1'b0; clear_byte_received = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_edge", d_edge, 0);
    check("rst_eop", eop, 0);
    check("rst_byte_received", byte_received, 0);
    check("rst_rcv_data", rcv_data, 8'h00);
    check("rst_count", count_bytes, 0);
    check("rst_stuff_error", stuff_error, 0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    drive_j(4);

    // Packet 1: sync, then 0xFF with a stuffed zero.
    edge_base = edge_cnt;
    send_sync();
    check("sync_edges", edge_cnt - edge_base, 7);
    check("sync_rcv_data", rcv_data, SYNC_BYTE);
    check("sync_byte_received", byte_received, 1);
    check("sync_count", count_bytes, 1);
    clear_byte_received = 1'b1;
    drive_k(1);
    clear_byte_received = 1'b0;
    check("clear_byte_received", byte_received, 0);
    drive_k(7);
    drive_k(32);
    drive_j(24);
    drive_j(7);
    clear_byte_received = 1'b1;
    drive_j(1);
    check("set_wins_over_clear", byte_received, 1);
    check("ff_rcv_data", rcv_data, 8'hFF);
    check("ff_count", count_bytes, 2);
    check("ff_stuff_error", stuff_error, 0);
    drive_j(1);
    clear_byte_received = 1'b0;
    check("clear_after_set", byte_received, 0);
    drive_se0(15);
    check("p1_eop", eop, 1);
    drive_j(16);
    check("p1_eop_cleared", eop, 0);
    check("p1_count_held", count_bytes, 2);

    // Packet 2: sync, 0xA5 (K J J K J J K K), SE0 for 2 bit times, J.
    send_sync();
    drive_k(8); drive_j(8); drive_j(8); drive_k(8);
    drive_j(8); drive_j(8); drive_k(16);
    check("a5_rcv_data", rcv_data, 8'hA5);
    check("a5_count", count_bytes, 2);
    drive_se0(7);
    check("eop_before_sample", eop, 0);
    drive_se0(1);
    check("eop_first_sample", eop, 1);
    drive_se0(8);
    check("eop_held", eop, 1);
    drive_j(2);
    check("eop_j_synced", eop, 1);
    drive_j(1);
    check("eop_dropped", eop, 0);
    drive_j(20);
    check("idle_count_held", count_bytes, 2);
    check("idle_rcv_data_held", rcv_data, 8'hA5);
    check("idle_state", 32'(dut.state_q), 32'(StIdle));

    // Packet 3: reset after three sampled bits.
    drive_k(8); drive_j(8); drive_k(8);
    drive_j(3);
    check("mid_d_edge", d_edge, 1);
    check("mid_count_cleared", count_bytes, 0);
    check("mid_rcv_data", rcv_data, 8'hA5);
    rst = 1'b1;
    #1;
    check("mrst_d_edge", d_edge, 0);
    check("mrst_rcv_data", rcv_data, 8'h00);
    check("mrst_byte_received", byte_received, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_j(1);
    check("mrst_state", 32'(dut.state_q), 32'(StIdle));
    check("mrst_eop", eop, 0);
    check("mrst_count", count_bytes, 0);
    drive_j(16);

    // Packet 4: sync then six more ones -> stuff bit decoded as 1.
    send_sync();
    drive_k(48);
    check("vio_eop", eop, 0);
    check("vio_count", count_bytes, 1);
`ifdef RX_STUFF_ERR_EN
    check("vio_stuff_error", stuff_error, 1);
    check("vio_state", 32'(dut.state_q), 32'(StEop));
`else
    check("vio_stuff_error", stuff_error, 0);
    check("vio_state", 32'(dut.state_q), 32'(StActive));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
